// File: rtl/data_mem_ctrl.sv
// Word-addressed data RAM behind the core data port, with a programmable wait-state handshake.
// Latency: a request seen in IDLE completes LATENCY+2 cycles later (IDLE -> BUSY x LATENCY+1 -> DONE).
// Backpressure: waitrequest holds the core off from the request cycle through BUSY and drops only in DONE.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   data_address          byte address from core (word aligned, inside the BASE window)
//   data_read/data_write  request strobes, held by the core until waitrequest=0
//   data_out, byteenable  write data and byte lanes (bit i -> bits [8i+7:8i])
//   data_in               read word, registered, holds until the next read or rejected completion
//   waitrequest           combinational stall to the core
//   addr_error            one-cycle pulse in DONE for a rejected request
module data_mem_ctrl #(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [31:0] BASE    = 32'h0000_1000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_out,
    input  logic [3:0]  byteenable,
    output logic [31:0] data_in,
    output logic        waitrequest,
    output logic        addr_error
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_idx;
    logic              lat_wr;
    logic              lat_bad;
    logic [31:0]       lat_dat;
    logic [3:0]        lat_be;

    logic [31:0]       mem [0:DEPTH-1];

    logic              req;
    logic              req_bad;
    logic              fire;
    logic              ram_we;

    assign req     = data_read | data_write;
    // Rejected: misaligned, outside the RAM window, or both strobes at once.
    assign req_bad = (data_address[1:0] != 2'b00)
                   || (data_address[31:ADDR_W+2] != BASE[31:ADDR_W+2])
                   || (data_read & data_write);
    // Last BUSY cycle: the access takes effect here, so a reset any earlier aborts it.
    assign fire    = (state == BUSY) && (cnt == 4'd0);
    assign ram_we  = fire && lat_wr && !lat_bad;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        waitrequest = 1'b0;
        case (state)
            IDLE:    waitrequest = req;
            BUSY:    waitrequest = 1'b1;
            DONE:    waitrequest = 1'b0;
            default: waitrequest = 1'b0;
        endcase
    end

    // Request capture, wait counter and read/error results. The core may change
    // or drop its request while BUSY; only the values captured in IDLE matter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 4'd0;
            lat_idx    <= '0;
            lat_wr     <= 1'b0;
            lat_bad    <= 1'b0;
            lat_dat    <= 32'd0;
            lat_be     <= 4'd0;
            data_in    <= 32'd0;
            addr_error <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                lat_idx <= data_address[ADDR_W+1:2];
                lat_wr  <= data_write;
                lat_bad <= req_bad;
                lat_dat <= data_out;
                lat_be  <= byteenable;
                cnt     <= 4'(LATENCY);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (fire) begin
                if (lat_bad) begin
                    data_in    <= 32'd0;
                    addr_error <= 1'b1;
                end else if (!lat_wr) begin
                    data_in <= mem[lat_idx];
                end
            end

            if (state == DONE) begin
                addr_error <= 1'b0;
            end
        end
    end

    // RAM array: contents survive reset. Only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_dat[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: instance 0 runs with LATENCY=2, instance 1 with LATENCY=0.
// Expected outputs come from a transaction-level model (word array + per-access cycle budget).
// A negedge monitor compares waitrequest/addr_error/data_in of both instances every cycle.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n   [2];
    logic [31:0] d_addr  [2];
    logic        d_rd    [2];
    logic        d_wr    [2];
    logic [31:0] d_dout  [2];
    logic [3:0]  d_be    [2];
    logic [31:0] d_din   [2];
    logic        d_wait  [2];
    logic        d_err   [2];

    // Model state and per-cycle expectations
    logic [31:0] mdl      [2][1024];
    logic        exp_wait [2];
    logic        exp_err  [2];
    logic [31:0] exp_din  [2];
    logic [15:0] wr_hist;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(.ADDR_W(10), .BASE(32'h0000_1000), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(rst_n[0]),
        .data_address(d_addr[0]), .data_read(d_rd[0]), .data_write(d_wr[0]),
        .data_out(d_dout[0]), .byteenable(d_be[0]),
        .data_in(d_din[0]), .waitrequest(d_wait[0]), .addr_error(d_err[0])
    );

    data_mem_ctrl #(.ADDR_W(10), .BASE(32'h0000_1000), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset(rst_n[1]),
        .data_address(d_addr[1]), .data_read(d_rd[1]), .data_write(d_wr[1]),
        .data_out(d_dout[1]), .byteenable(d_be[1]),
        .data_in(d_din[1]), .waitrequest(d_wait[1]), .addr_error(d_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input int ii, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %h expected %h", name, ii, $time, act, exp);
        end
    endtask

    // Compare process: both instances, every cycle, away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            cmp("waitrequest", i, {31'd0, d_wait[i]}, {31'd0, exp_wait[i]});
            cmp("addr_error",  i, {31'd0, d_err[i]},  {31'd0, exp_err[i]});
            cmp("data_in",     i, d_din[i], exp_din[i]);
        end
    end

    // One complete access starting in the current IDLE cycle (entered at posedge+1).
    // Returns at posedge+1 of the cycle after DONE with the request still driven;
    // the caller follows with another access (back-to-back) or go_idle.
    task automatic access(input int ii, input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input bit mangle);
        int  lat;
        bit  bad;
        int  idx;
        lat = (ii == 0) ? 2 : 0;
        d_addr[ii] = addr; d_rd[ii] = rd; d_wr[ii] = wr; d_dout[ii] = wd; d_be[ii] = be;
        exp_wait[ii] = 1'b1;
        exp_err[ii]  = 1'b0;
        // Request cycle plus LATENCY+1 busy cycles: stall throughout.
        for (int k = 0; k < lat + 2; k++) begin
            if (k > 0 && mangle) begin
                d_addr[ii] = addr ^ 32'h8; d_rd[ii] = 1'b0; d_wr[ii] = 1'b0;
                d_dout[ii] = ~wd; d_be[ii] = ~be;
            end
            #2 wr_hist = {wr_hist[14:0], d_wait[ii]};
            @(posedge clk) #1;
        end
        // Completion cycle: apply the access to the model.
        bad = (addr % 4 != 0) || (addr < 32'h1000) || (addr > 32'h1FFF) || (rd && wr);
        idx = int'((addr - 32'h1000) / 4);
        if (bad) begin
            exp_err[ii] = 1'b1;
            exp_din[ii] = 32'd0;
        end else if (rd) begin
            exp_din[ii] = mdl[ii][idx];
        end else begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mdl[ii][idx][8*b +: 8] = wd[8*b +: 8];
        end
        exp_wait[ii] = 1'b0;
        #2 wr_hist = {wr_hist[14:0], d_wait[ii]};
        @(posedge clk) #1;
        exp_err[ii] = 1'b0;
    endtask

    task automatic go_idle(input int ii);
        d_rd[ii] = 1'b0; d_wr[ii] = 1'b0;
        exp_wait[ii] = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic wr_word(input int ii, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        access(ii, 1'b0, 1'b1, addr, wd, be, 1'b0);
        go_idle(ii);
    endtask

    task automatic rd_word(input int ii, input logic [31:0] addr);
        access(ii, 1'b1, 1'b0, addr, 32'd0, 4'h0, 1'b0);
        go_idle(ii);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; d_addr[i] = 32'd0; d_rd[i] = 1'b0; d_wr[i] = 1'b0;
            d_dout[i] = 32'd0; d_be[i] = 4'd0;
            exp_wait[i] = 1'b0; exp_err[i] = 1'b0; exp_din[i] = 32'd0;
        end
        wr_hist = 16'd0;
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        @(posedge clk) #1;

        // ---- LATENCY=2 ----
        wr_hist = 16'd0;
        access(0, 1'b0, 1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 1'b0);
        cmp("wait_pattern_lat2", 0, {27'd0, wr_hist[4:0]}, 32'h0000_001E);
        go_idle(0);
        rd_word(0, 32'h1004);
        cmp("lit_read_deadbeef", 0, d_din[0], 32'hDEADBEEF);

        wr_word(0, 32'h1004, 32'h0000AA00, 4'b0010);
        rd_word(0, 32'h1004);
        cmp("lit_read_byte_lane", 0, d_din[0], 32'hDEADAAEF);

        // Rejected requests: misaligned, outside window, both strobes.
        rd_word(0, 32'h1002);
        rd_word(0, 32'h0000_0100);
        rd_word(0, 32'h1004);
        cmp("lit_ram_kept", 0, d_din[0], 32'hDEADAAEF);
        wr_word(0, 32'h0000_2004, 32'hFFFF_FFFF, 4'hF);
        wr_word(0, 32'h1008, 32'hCAFEF00D, 4'hF);
        access(0, 1'b1, 1'b1, 32'h1008, 32'h11111111, 4'hF, 1'b0);
        go_idle(0);
        rd_word(0, 32'h1008);
        cmp("lit_conflict_kept", 0, d_din[0], 32'hCAFEF00D);

        // Empty byteenable completes without touching the word.
        wr_word(0, 32'h1008, 32'h0, 4'b0000);
        rd_word(0, 32'h1008);

        // Request mangled and dropped during BUSY: captured values still apply.
        wr_word(0, 32'h1000, 32'h0, 4'hF);
        access(0, 1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF, 1'b1);
        go_idle(0);
        rd_word(0, 32'h1000);
        cmp("lit_mangled_write", 0, d_din[0], 32'hA5A5A5A5);
        rd_word(0, 32'h1008);

        // Reset in BUSY with one wait cycle left aborts the write.
        wr_word(0, 32'h100C, 32'h0BADF00D, 4'hF);
        d_addr[0] = 32'h100C; d_wr[0] = 1'b1; d_dout[0] = 32'h12345678; d_be[0] = 4'hF;
        exp_wait[0] = 1'b1;
        @(posedge clk) #1;            // BUSY, counter at LATENCY
        @(posedge clk) #1;            // BUSY, counter at 1
        rst_n[0] = 1'b0;
        d_wr[0] = 1'b0;
        exp_wait[0] = 1'b0; exp_err[0] = 1'b0; exp_din[0] = 32'd0;
        @(posedge clk) #1;
        @(posedge clk) #1;
        rst_n[0] = 1'b1;
        @(posedge clk) #1;
        rd_word(0, 32'h100C);
        cmp("lit_reset_abort", 0, d_din[0], 32'h0BADF00D);

        // ---- LATENCY=0 ----
        wr_word(1, 32'h1000, 32'h01020304, 4'hF);
        wr_word(1, 32'h1004, 32'h05060708, 4'hF);
        wr_hist = 16'd0;
        access(1, 1'b1, 1'b0, 32'h1000, 32'd0, 4'h0, 1'b0);
        cmp("lit_b2b_first", 1, d_din[1], 32'h01020304);
        access(1, 1'b1, 1'b0, 32'h1004, 32'd0, 4'h0, 1'b0);
        cmp("wait_pattern_b2b", 1, {26'd0, wr_hist[5:0]}, 32'h0000_0036);
        go_idle(1);
        cmp("lit_b2b_second", 1, d_din[1], 32'h05060708);
        rd_word(1, 32'h0000_1001);
        @(posedge clk) #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
